// File: rtl/qlal4s3_mac_seq.sv
// Sequencer for the QL hard 16x16 multiplier. It feeds operand pairs to the
// multiplier and accumulates the returned products into a dot product.
// One pair can be accepted per cycle. A pair flagged last closes the sum and
// holds the result until the consumer takes it.
module qlal4s3_mac_seq #(
    parameter int ACC_WIDTH = 40
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [15:0]          IN_A,
    input  logic [15:0]          IN_B,
    input  logic                 IN_LAST,
    output logic [15:0]          MULT_A,
    output logic [15:0]          MULT_B,
    output logic [1:0]           MULT_VALID,
    input  logic [31:0]          MULT_C,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [ACC_WIDTH-1:0] OUT_ACC,
    output logic                 OUT_OVF
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t               state, state_nxt;
    logic                 s1_vld, s1_last;
    logic                 xfer_in, xfer_out;
    logic [ACC_WIDTH-1:0] acc, prod_ext, sum;
    logic                 ovf, ovf_now;

    // Product comes back combinationally from the hard block; widen it with sign extension.
    assign prod_ext = ACC_WIDTH'($signed(MULT_C));
    assign sum      = acc + prod_ext;
    assign ovf_now  = (acc[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                      (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);

    assign xfer_in    = IN_VALID && IN_READY;
    assign xfer_out   = OUT_VALID && OUT_READY;
    assign MULT_VALID = {1'b0, s1_vld};
    assign OUT_ACC    = acc;
    assign OUT_OVF    = ovf;

    // Next-state and ready: stop accepting once the closing pair is in flight.
    always_comb begin
        state_nxt = state;
        IN_READY  = 1'b0;
        case (state)
            IDLE: begin
                IN_READY = !(s1_vld && s1_last);
                if (xfer_in) state_nxt = RUN;
            end
            RUN: begin
                IN_READY = !(s1_vld && s1_last);
                if (s1_vld && s1_last) state_nxt = HOLD;
            end
            HOLD: begin
                if (xfer_out) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // Stage 1: operands to the multiplier. They are held when idle, and valid is a one-cycle pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            MULT_A  <= '0;
            MULT_B  <= '0;
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
        end else begin
            s1_vld <= xfer_in;
            if (xfer_in) begin
                MULT_A  <= IN_A;
                MULT_B  <= IN_B;
                s1_last <= IN_LAST;
            end
        end
    end

    // Accumulator, sticky overflow and result valid. A result transfer starts a fresh sum.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc       <= '0;
            ovf       <= 1'b0;
            OUT_VALID <= 1'b0;
        end else if (xfer_out) begin
            acc       <= '0;
            ovf       <= 1'b0;
            OUT_VALID <= 1'b0;
        end else if (s1_vld) begin
            acc <= sum;
            ovf <= ovf | ovf_now;
            if (s1_last) OUT_VALID <= 1'b1;
        end
    end

endmodule

// File: tb/tb_qlal4s3_mac_seq.sv
// Directed bench for qlal4s3_mac_seq: two instances (ACC_WIDTH 40 and 32) share stimulus.
module tb_qlal4s3_mac_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [15:0] in_a = '0, in_b = '0;

    logic        rdy40, rdy32, ov40, ov32, vo40, vo32, ovf40, ovf32;
    logic [15:0] ma40, mb40, ma32, mb32;
    logic [1:0]  mv40, mv32;
    logic [31:0] mc40, mc32;
    logic [39:0] acc40;
    logic [31:0] acc32;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Hard multiplier model
    assign mc40 = 32'($signed(ma40) * $signed(mb40));
    assign mc32 = 32'($signed(ma32) * $signed(mb32));

    qlal4s3_mac_seq #(.ACC_WIDTH(40)) dut (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(rdy40),
        .IN_A(in_a), .IN_B(in_b), .IN_LAST(in_last),
        .MULT_A(ma40), .MULT_B(mb40), .MULT_VALID(mv40), .MULT_C(mc40),
        .OUT_VALID(vo40), .OUT_READY(out_ready), .OUT_ACC(acc40), .OUT_OVF(ovf40));

    qlal4s3_mac_seq #(.ACC_WIDTH(32)) dut32 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(rdy32),
        .IN_A(in_a), .IN_B(in_b), .IN_LAST(in_last),
        .MULT_A(ma32), .MULT_B(mb32), .MULT_VALID(mv32), .MULT_C(mc32),
        .OUT_VALID(vo32), .OUT_READY(out_ready), .OUT_ACC(acc32), .OUT_OVF(ovf32));

    assign ov40 = ovf40;
    assign ov32 = ovf32;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a pair, wait (bounded) for ready, let it transfer, then drop valid.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
        int n;
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        n = 0;
        while (!rdy40 && n < 20) begin
            tick();
            n++;
        end
        chk("ready_wait", 64'(rdy40), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("mv_pulse", 64'(mv40), 64'd1);
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!vo40 && n < 20) begin
            tick();
            n++;
        end
        chk("out_wait", 64'(vo40), 64'd1);
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_acc", 64'(acc40), 64'd0);
        chk("rst_vld", 64'(vo40), 64'd0);
        chk("rst_mv", 64'(mv40), 64'd0);
        #3 rst_n = 1'b1;
        tick();
        chk("rdy_after_rst", 64'(rdy40), 64'd1);

        // (3,4),(-2,5,last) back-to-back, 3*4 - 2*5 = 2
        out_ready = 1'b1;
        send(16'd3, 16'd4, 1'b0);
        chk("ma_3", 64'(ma40), 64'd3);
        send(-16'sd2, 16'd5, 1'b1);
        chk("acc_partial", 64'($signed(acc40)), 64'd12);
        chk("rdy_last_in_s1", 64'(rdy40), 64'd0);
        chk("vld_not_yet", 64'(vo40), 64'd0);
        tick();
        chk("vld_dp1", 64'(vo40), 64'd1);
        chk("acc_dp1", 64'($signed(acc40)), 64'd2);
        chk("ovf_dp1", 64'(ov40), 64'd0);
        tick();
        chk("vld_clr", 64'(vo40), 64'd0);
        chk("acc_clr", 64'(acc40), 64'd0);
        chk("rdy_back", 64'(rdy40), 64'd1);

        // (-32768)^2 single term = 0x40000000; multiplier valid exactly one cycle
        send(16'h8000, 16'h8000, 1'b1);
        tick();
        chk("mv_drop", 64'(mv40), 64'd0);
        chk("acc_min2", 64'(acc40), 64'h40000000);
        chk("acc32_min2", 64'(acc32), 64'h40000000);
        tick();

        // Backpressure: 100*-3 = -300 held for 3 cycles
        out_ready = 1'b0;
        send(16'd100, -16'sd3, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("hold_vld", 64'(vo40), 64'd1);
            chk("hold_acc", 64'($signed(acc40)), -64'sd300);
            chk("hold_rdy", 64'(rdy40), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        chk("hold_rdy4", 64'(rdy40), 64'd0);
        tick();
        chk("rdy_after_xfer", 64'(rdy40), 64'd1);
        chk("vld_after_xfer", 64'(vo40), 64'd0);

        // 3 * 32767^2 = 0xBFFD0003: wraps negative at 32 bits, fits at 40 bits
        out_ready = 1'b0;
        send(16'd32767, 16'd32767, 1'b0);
        send(16'd32767, 16'd32767, 1'b0);
        send(16'd32767, 16'd32767, 1'b1);
        wait_out();
        chk("acc32_wrap", 64'(acc32), 64'hBFFD0003);
        chk("ovf32_set", 64'(ov32), 64'd1);
        chk("acc40_nowrap", 64'($signed(acc40)), 64'h00000000BFFD0003);
        chk("ovf40_clr", 64'(ov40), 64'd0);
        tick();
        chk("ovf32_sticky", 64'(ov32), 64'd1);
        out_ready = 1'b1;
        tick();
        chk("ovf32_cleared", 64'(ov32), 64'd0);
        send(16'd1, 16'd2, 1'b1);
        chk("ovf32_next", 64'(ov32), 64'd0);
        wait_out();
        chk("acc32_next", 64'(acc32), 64'd2);
        tick();

        // Reset after 2 of 4 pairs
        send(16'd5, 16'd6, 1'b0);
        send(16'd7, 16'd8, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst_acc", 64'(acc40), 64'd0);
        chk("mrst_ma", 64'(ma40), 64'd0);
        chk("mrst_mb", 64'(mb40), 64'd0);
        chk("mrst_mv", 64'(mv40), 64'd0);
        chk("mrst_vld", 64'(vo40), 64'd0);
        chk("mrst_ovf", 64'(ov40), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mrst_rdy", 64'(rdy40), 64'd1);
        send(16'd1, 16'd1, 1'b1);
        wait_out();
        chk("mrst_acc1", 64'($signed(acc40)), 64'd1);
        tick();

        // Gapped input: 10*-20 + 300*7 + -5*-5 = 1925
        send(16'd10, -16'sd20, 1'b0);
        tick();
        chk("gap_mv1", 64'(mv40), 64'd0);
        send(16'd300, 16'd7, 1'b0);
        tick();
        chk("gap_mv2", 64'(mv40), 64'd0);
        send(-16'sd5, -16'sd5, 1'b1);
        wait_out();
        chk("gap_acc", 64'($signed(acc40)), 64'd1925);
        chk("gap_acc32", 64'(acc32), 64'd1925);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
